// File: rtl/fp_result_pack_pipe_if.sv
// Handshake and data bundle between the add/sub core, the result packer and the result register file.
// The slave modport is the packer's view of the bundle.
interface fp_result_pack_pipe_if #(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int EXTRA_W = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_sign;
    logic [EXP_W:0]             in_exp;
    logic [MAN_W+EXTRA_W-1:0]   in_man;
    logic [1:0]                 in_class;
    logic [1:0]                 round_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [EXP_W+MAN_W:0]       out_result;
    logic                       out_qnan;
    logic                       out_snan;
    logic                       out_inf;
    logic                       out_zero;
    logic                       out_overflow;
    logic                       out_inexact;

    modport slave (
        input  in_valid, in_sign, in_exp, in_man, in_class, round_mode, out_ready,
        output in_ready, out_valid, out_result,
        output out_qnan, out_snan, out_inf, out_zero, out_overflow, out_inexact
    );

    modport master (
        output in_valid, in_sign, in_exp, in_man, in_class, round_mode, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_qnan, out_snan, out_inf, out_zero, out_overflow, out_inexact
    );
endinterface

// File: rtl/fp_result_pack_pipe.sv
// Two-stage elastic float result packer: rounding in stage 1; exponent carry, saturation,
// special-value encoding and status flags in stage 2.
module fp_result_pack_pipe #(
    parameter int EXP_W      = 5,
    parameter int MAN_W      = 10,
    parameter int EXTRA_W    = 3,
    parameter bit QUIET_SNAN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fp_result_pack_pipe_if.slave   io_bus
);
    localparam int IN_W = MAN_W + EXTRA_W;

    localparam logic [1:0] CLS_FIN  = 2'b00;
    localparam logic [1:0] CLS_INF  = 2'b01;
    localparam logic [1:0] CLS_NAN  = 2'b10;
    localparam logic [1:0] CLS_ZERO = 2'b11;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_POS = 2'b10;
    localparam logic [1:0] RM_NEG = 2'b11;

    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0] FRAC_ONES = {MAN_W{1'b1}};
    localparam logic [MAN_W-1:0] FRAC_QBIT = {1'b1, {(MAN_W-1){1'b0}}};

    // pipeline registers
    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic [EXP_W:0]       r_s1_exp;
    logic [1:0]           r_s1_class;
    logic [1:0]           r_s1_rmode;
    logic [MAN_W:0]       r_s1_frac;
    logic                 r_s1_inexact;

    logic                 r_s2_valid;
    logic [EXP_W+MAN_W:0] r_s2_result;
    logic                 r_s2_qnan;
    logic                 r_s2_snan;
    logic                 r_s2_inf;
    logic                 r_s2_zero;
    logic                 r_s2_overflow;
    logic                 r_s2_inexact;

    // handshake
    logic w_s2_load;
    logic w_s1_move;
    logic w_in_ready;
    logic w_in_fire;

    assign w_s2_load  = !r_s2_valid || io_bus.out_ready;
    assign w_s1_move  = r_s1_valid && w_s2_load;
    assign w_in_ready = !r_s1_valid || w_s1_move;
    assign w_in_fire  = io_bus.in_valid && w_in_ready;

    assign io_bus.in_ready = w_in_ready;

    // stage 1: rounding decision
    logic [MAN_W-1:0] w_keep;
    logic             w_guard;
    logic             w_sticky;
    logic             w_lost;
    logic             w_is_fin;
    logic             w_inc;
    logic [MAN_W:0]   w_frac_rnd;

    assign w_keep   = io_bus.in_man[IN_W-1:EXTRA_W];
    assign w_guard  = io_bus.in_man[EXTRA_W-1];
    assign w_sticky = |io_bus.in_man[EXTRA_W-2:0];
    assign w_lost   = w_guard || w_sticky;
    assign w_is_fin = (io_bus.in_class == CLS_FIN);

    always_comb begin
        w_inc = 1'b0;
        case (io_bus.round_mode)
            RM_RNE:  w_inc = w_guard && (w_sticky || w_keep[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_POS:  w_inc = !io_bus.in_sign && w_lost;
            RM_NEG:  w_inc = io_bus.in_sign && w_lost;
            default: w_inc = 1'b0;
        endcase
    end

    // NaN payloads ride through the same register unrounded
    assign w_frac_rnd = {1'b0, w_keep} + {{MAN_W{1'b0}}, (w_inc && w_is_fin)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_class   <= 2'b00;
            r_s1_rmode   <= 2'b00;
            r_s1_frac    <= '0;
            r_s1_inexact <= 1'b0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= io_bus.in_valid;
            end
            if (w_in_fire) begin
                r_s1_sign    <= io_bus.in_sign;
                r_s1_exp     <= io_bus.in_exp;
                r_s1_class   <= io_bus.in_class;
                r_s1_rmode   <= io_bus.round_mode;
                r_s1_frac    <= w_frac_rnd;
                r_s1_inexact <= w_is_fin && w_lost;
            end
        end
    end

    // stage 2: carry into exponent, saturation, classification
    logic                 w_carry;
    logic [EXP_W+1:0]     w_exp_fin;
    logic [MAN_W-1:0]     w_frac_fin;
    logic                 w_ovf;
    logic                 w_to_inf;
    logic [MAN_W-1:0]     w_payload;

    logic [EXP_W-1:0]     w_res_exp;
    logic [MAN_W-1:0]     w_res_frac;
    logic                 w_qnan;
    logic                 w_snan;
    logic                 w_inf;
    logic                 w_zero;
    logic                 w_overflow;
    logic                 w_inexact;

    assign w_carry    = r_s1_frac[MAN_W];
    assign w_exp_fin  = {1'b0, r_s1_exp} + {{(EXP_W+1){1'b0}}, w_carry};
    assign w_frac_fin = w_carry ? '0 : r_s1_frac[MAN_W-1:0];
    assign w_ovf      = (w_exp_fin >= {2'b00, EXP_ONES});
    assign w_payload  = r_s1_frac[MAN_W-1:0];

    // RTZ and the "wrong-direction" directed modes clamp to max finite
    assign w_to_inf = (r_s1_rmode == RM_RNE) ||
                      ((r_s1_rmode == RM_POS) && !r_s1_sign) ||
                      ((r_s1_rmode == RM_NEG) && r_s1_sign);

    always_comb begin
        w_res_exp  = '0;
        w_res_frac = '0;
        w_qnan     = 1'b0;
        w_snan     = 1'b0;
        w_inf      = 1'b0;
        w_zero     = 1'b0;
        w_overflow = 1'b0;
        w_inexact  = 1'b0;
        case (r_s1_class)
            CLS_FIN: begin
                if (w_ovf) begin
                    w_overflow = 1'b1;
                    w_inexact  = 1'b1;
                    if (w_to_inf) begin
                        w_res_exp = EXP_ONES;
                        w_inf     = 1'b1;
                    end else begin
                        w_res_exp  = EXP_MAXF;
                        w_res_frac = FRAC_ONES;
                    end
                end else begin
                    w_res_exp  = w_exp_fin[EXP_W-1:0];
                    w_res_frac = w_frac_fin;
                    w_inexact  = r_s1_inexact;
                    w_zero     = (w_exp_fin[EXP_W-1:0] == '0) && (w_frac_fin == '0);
                end
            end
            CLS_INF: begin
                w_res_exp = EXP_ONES;
                w_inf     = 1'b1;
            end
            CLS_NAN: begin
                w_res_exp = EXP_ONES;
                if (w_payload[MAN_W-1]) begin
                    w_qnan     = 1'b1;
                    w_res_frac = w_payload;
                end else if (|w_payload) begin
                    w_snan     = 1'b1;
                    w_res_frac = QUIET_SNAN ? (w_payload | FRAC_QBIT) : w_payload;
                end else begin
                    w_qnan     = 1'b1;
                    w_res_frac = FRAC_QBIT;
                end
            end
            CLS_ZERO: begin
                w_zero = 1'b1;
            end
            default: begin
                w_zero = 1'b0;
            end
        endcase
    end

    // a bubble entering stage 2 clears the word and flags so idle outputs read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_s2_result   <= '0;
            r_s2_qnan     <= 1'b0;
            r_s2_snan     <= 1'b0;
            r_s2_inf      <= 1'b0;
            r_s2_zero     <= 1'b0;
            r_s2_overflow <= 1'b0;
            r_s2_inexact  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result   <= {r_s1_sign, w_res_exp, w_res_frac};
                r_s2_qnan     <= w_qnan;
                r_s2_snan     <= w_snan;
                r_s2_inf      <= w_inf;
                r_s2_zero     <= w_zero;
                r_s2_overflow <= w_overflow;
                r_s2_inexact  <= w_inexact;
            end else begin
                r_s2_result   <= '0;
                r_s2_qnan     <= 1'b0;
                r_s2_snan     <= 1'b0;
                r_s2_inf      <= 1'b0;
                r_s2_zero     <= 1'b0;
                r_s2_overflow <= 1'b0;
                r_s2_inexact  <= 1'b0;
            end
        end
    end

    assign io_bus.out_valid    = r_s2_valid;
    assign io_bus.out_result   = r_s2_result;
    assign io_bus.out_qnan     = r_s2_qnan;
    assign io_bus.out_snan     = r_s2_snan;
    assign io_bus.out_inf      = r_s2_inf;
    assign io_bus.out_zero     = r_s2_zero;
    assign io_bus.out_overflow = r_s2_overflow;
    assign io_bus.out_inexact  = r_s2_inexact;

endmodule

// File: tb/tb_fp_result_pack_pipe.sv
// Bench for fp_result_pack_pipe: directed vector table, backpressure and reset sequences,
// then randomized traffic scored against an arithmetic reference model.
module tb_fp_result_pack_pipe;
    localparam int EXP_W      = 5;
    localparam int MAN_W      = 10;
    localparam int EXTRA_W    = 3;
    localparam bit QUIET_SNAN = 1'b1;
    localparam int RW         = 1 + EXP_W + MAN_W;
    localparam int EW         = RW + 6;

    logic clk;
    logic rst_n;

    fp_result_pack_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .EXTRA_W(EXTRA_W)) bus ();

    fp_result_pack_pipe #(
        .EXP_W(EXP_W), .MAN_W(MAN_W), .EXTRA_W(EXTRA_W), .QUIET_SNAN(QUIET_SNAN)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected word = {result, qnan, snan, inf, zero, overflow, inexact}
    function automatic logic [EW-1:0] model(input bit sign, input int e, input int man,
                                            input int cls, input int rm);
        int  keep, g, s, inc, f, ee, emax, fmax, half;
        bit  qn, sn, inf, zr, ov, ix, to_inf;
        logic [RW-1:0] r;
        emax = (1 << EXP_W) - 1;
        fmax = (1 << MAN_W) - 1;
        half = 1 << (MAN_W - 1);
        keep = man >> EXTRA_W;
        g    = (man >> (EXTRA_W - 1)) & 1;
        s    = ((man & ((1 << (EXTRA_W - 1)) - 1)) != 0) ? 1 : 0;
        {qn, sn, inf, zr, ov, ix} = 6'b0;
        r = '0;
        case (cls)
            0: begin
                case (rm)
                    0: inc = (g == 1 && (s == 1 || (keep % 2) == 1)) ? 1 : 0;
                    1: inc = 0;
                    2: inc = (!sign && (g + s) > 0) ? 1 : 0;
                    default: inc = (sign && (g + s) > 0) ? 1 : 0;
                endcase
                f  = keep + inc;
                ee = e;
                if (f > fmax) begin
                    f  = 0;
                    ee = ee + 1;
                end
                ix = (g + s) > 0;
                if (ee >= emax) begin
                    ov = 1; ix = 1;
                    to_inf = (rm == 0) || (rm == 2 && !sign) || (rm == 3 && sign);
                    if (to_inf) begin
                        inf = 1;
                        r = {sign, EXP_W'(emax), MAN_W'(0)};
                    end else begin
                        r = {sign, EXP_W'(emax - 1), MAN_W'(fmax)};
                    end
                end else begin
                    r  = {sign, EXP_W'(ee), MAN_W'(f)};
                    zr = (ee == 0 && f == 0);
                end
            end
            1: begin
                inf = 1;
                r = {sign, EXP_W'(emax), MAN_W'(0)};
            end
            2: begin
                if (keep >= half) begin
                    qn = 1; r = {sign, EXP_W'(emax), MAN_W'(keep)};
                end else if (keep != 0) begin
                    sn = 1; r = {sign, EXP_W'(emax), MAN_W'(QUIET_SNAN ? keep + half : keep)};
                end else begin
                    qn = 1; r = {sign, EXP_W'(emax), MAN_W'(half)};
                end
            end
            default: begin
                zr = 1;
                r = {sign, EXP_W'(0), MAN_W'(0)};
            end
        endcase
        return {r, qn, sn, inf, zr, ov, ix};
    endfunction

    logic [EW-1:0] sb[$];
    int            out_cyc[$];
    int            cyc = 0;
    bit            rand_rdy  = 1'b0;
    bit            fixed_rdy = 1'b1;

    // sole driver of out_ready, updated after the edge
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
        end
    end

    function automatic logic [EW-1:0] dut_word();
        return {bus.out_result, bus.out_qnan, bus.out_snan, bus.out_inf,
                bus.out_zero, bus.out_overflow, bus.out_inexact};
    endfunction

    // output monitor: scoreboard, stall stability, idle flags
    initial begin
        bit            hold = 1'b0;
        logic [EW-1:0] prev = '0;
        logic [EW-1:0] exp_w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            cyc++;
            if (hold) chk("stall_stable", {bus.out_valid, dut_word()}, {1'b1, prev});
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    exp_w = sb.pop_front();
                    chk("out_word", 64'(dut_word()), 64'(exp_w));
                end
                out_cyc.push_back(cyc);
            end
            if (!bus.out_valid) chk("idle_flags", 64'(dut_word() & 22'h3F), 64'd0);
            hold = bus.out_valid && !bus.out_ready;
            prev = dut_word();
        end
    end

    task automatic drive(input bit s, input int e, input int m, input int c, input int rm);
        bus.in_valid   = 1'b1;
        bus.in_sign    = s;
        bus.in_exp     = (EXP_W+1)'(e);
        bus.in_man     = (MAN_W+EXTRA_W)'(m);
        bus.in_class   = 2'(c);
        bus.round_mode = 2'(rm);
    endtask

    task automatic send(input bit s, input int e, input int m, input int c, input int rm,
                        input logic [EW-1:0] exp_w);
        int waited = 0;
        drive(s, e, m, c, rm);
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 100) begin
                chk("in_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        if (waited <= 100) sb.push_back(exp_w);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit            s;
        int            e;
        int            m;
        int            c;
        int            rm;
        logic [RW-1:0] res;
        logic [5:0]    flg;   // qnan snan inf zero overflow inexact
    } vec_t;

    vec_t vecs[$];

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_sign    = 1'b0;
        bus.in_exp     = '0;
        bus.in_man     = '0;
        bus.in_class   = 2'b00;
        bus.round_mode = 2'b00;
        rst_n          = 1'b0;

        vecs.push_back('{0, 15, 13'h000C, 0, 0, 16'h3C02, 6'b000001});
        vecs.push_back('{0, 15, 13'h0014, 0, 0, 16'h3C02, 6'b000001});
        vecs.push_back('{0, 15, 13'h0015, 0, 0, 16'h3C03, 6'b000001});
        vecs.push_back('{0, 15, 13'h1FFE, 0, 0, 16'h4000, 6'b000001});
        vecs.push_back('{0, 30, 13'h1FFC, 0, 0, 16'h7C00, 6'b001011});
        vecs.push_back('{0, 31, 13'h0000, 0, 1, 16'h7BFF, 6'b000011});
        vecs.push_back('{1, 31, 13'h0000, 0, 3, 16'hFC00, 6'b001011});
        vecs.push_back('{0, 32, 13'h0000, 0, 3, 16'h7BFF, 6'b000011});
        vecs.push_back('{0, 30, 13'h1FF9, 0, 3, 16'h7BFF, 6'b000001});
        vecs.push_back('{0, 15, 13'h0001, 0, 2, 16'h3C01, 6'b000001});
        vecs.push_back('{0,  0, 13'h1FFC, 0, 0, 16'h0400, 6'b000001});
        vecs.push_back('{0,  0, 13'h0000, 0, 0, 16'h0000, 6'b000100});
        vecs.push_back('{0,  0, 13'h0800, 2, 0, 16'h7F00, 6'b010000});
        vecs.push_back('{0,  0, 13'h1000, 2, 0, 16'h7E00, 6'b100000});
        vecs.push_back('{0,  0, 13'h0000, 2, 0, 16'h7E00, 6'b100000});
        vecs.push_back('{1,  0, 13'h1008, 2, 0, 16'hFE01, 6'b100000});
        vecs.push_back('{1,  9, 13'h0123, 1, 0, 16'hFC00, 6'b001000});
        vecs.push_back('{1,  9, 13'h0123, 3, 0, 16'h8000, 6'b000100});

        // reset state
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_word", 64'(dut_word()), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // directed table, streamed back-to-back
        foreach (vecs[i]) send(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].c, vecs[i].rm,
                               {vecs[i].res, vecs[i].flg});
        drain();

        // backpressure: four words, downstream stalled
        fixed_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_cyc.delete();
        drive(0, 15, 13'h000C, 0, 0);
        @(negedge clk);
        chk("bp_accept1", 64'(bus.in_ready), 64'd1);
        sb.push_back({16'h3C02, 6'b000001});
        @(posedge clk);
        #1;
        drive(0, 16, 13'h0008, 0, 0);
        @(negedge clk);
        chk("bp_accept2", 64'(bus.in_ready), 64'd1);
        sb.push_back({16'h4001, 6'b000000});
        @(posedge clk);
        #1;
        drive(1, 17, 13'h0010, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_full", 64'(bus.in_ready), 64'd0);
            chk("bp_hold_word1", 64'({bus.out_valid, bus.out_result}), 64'({1'b1, 16'h3C02}));
            @(posedge clk);
            #1;
        end
        fixed_rdy = 1'b1;
        send(1, 17, 13'h0010, 0, 1, {16'hC402, 6'b000000});
        send(0, 18, 13'h0018, 0, 0, {16'h4803, 6'b000000});
        drain();
        chk("bp_out_count", 64'(out_cyc.size()), 64'd4);
        if (out_cyc.size() == 4)
            chk("bp_back_to_back", 64'(out_cyc[3] - out_cyc[0]), 64'd3);

        // reset with two words in flight
        fixed_rdy = 1'b0;
        @(posedge clk);
        #1;
        send(0, 15, 13'h0000, 0, 0, '0);
        send(0, 16, 13'h0000, 0, 0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_word", 64'(dut_word()), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        fixed_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("post_rst_no_stale", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // randomized traffic against the reference model
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            bit s;
            int e, m, c, rm, sel;
            s   = $urandom_range(0, 1);
            sel = $urandom_range(0, 9);
            c   = (sel < 7) ? 0 : $urandom_range(1, 3);
            e   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 31);
            m   = $urandom_range(0, (1 << (MAN_W + EXTRA_W)) - 1);
            if ($urandom_range(0, 5) == 0) m = m | 13'h1FF8;
            rm  = $urandom_range(0, 3);
            send(s, e, m, c, rm, model(s, e, m, c, rm));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        fixed_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
